os_result_drain: RTL and testbench

OS_RESULT_DRAIN -- requirements
Module: os_result_drain

---
 rtl/os_result_drain.sv | 167 ++++++++++++++++
 tb/tb_os_result_drain.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_result_drain.sv
// Sequences one compute pass of an output-stationary PE array, captures the shifted-out results
// and streams them out one word per handshake. Optional build macro: DRAIN_REORDER_EN.
module os_result_drain #(
    parameter int OUT_WORD_SIZE  = 16,
    parameter int ROW            = 1,
    parameter int COLUMN         = 4,
    parameter int INPUTS_LENGTHS = 7
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ROW*OUT_WORD_SIZE-1:0]           result_in,
    output logic                                   op_sel,
    output logic                                   busy,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_WORD_SIZE-1:0]               out_data,
    output logic [((ROW > 1) ? $clog2(ROW) : 1)-1:0]       out_row,
    output logic [((COLUMN > 1) ? $clog2(COLUMN) : 1)-1:0] out_col,
    output logic                                   out_last
);

    localparam int ROW_W   = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int COL_W   = (COLUMN > 1) ? $clog2(COLUMN) : 1;
    localparam int CNT_MAX = (INPUTS_LENGTHS + 1 > COLUMN) ? INPUTS_LENGTHS + 1 : COLUMN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

`ifdef DRAIN_REORDER_EN
    localparam logic REORDER = 1'b1;
`else
    localparam logic REORDER = 1'b0;
`endif

    localparam logic [COL_W-1:0] TOP_SLOT     = COL_W'(COLUMN - 1);
    localparam logic [COL_W-1:0] FIRST_SLOT   = REORDER ? TOP_SLOT : '0;
    localparam logic [COL_W-1:0] LAST_SLOT    = REORDER ? '0 : TOP_SLOT;
    localparam logic [CNT_W-1:0] COMPUTE_LAST = CNT_W'(INPUTS_LENGTHS);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(COLUMN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROW - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUTPUT} state_t;

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic                      op_sel_d, busy_d, out_valid_d, out_last_d;
    logic [OUT_WORD_SIZE-1:0]  out_data_d;
    logic [ROW_W-1:0]          out_row_d, next_row;
    logic [COL_W-1:0]          out_col_d, next_slot;
    logic [COL_W-1:0]          cap_slot;
    logic [OUT_WORD_SIZE-1:0]  buffer [ROW][COLUMN];

    assign cap_slot = cnt[COL_W-1:0];

    // NOTE: the result buffer is plain storage with no reset; every slot is rewritten during
    // DRAIN before it can be read, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (state == DRAIN) begin
            for (int r = 0; r < ROW; r++) begin
                buffer[r][cap_slot] <= result_in[r*OUT_WORD_SIZE +: OUT_WORD_SIZE];
            end
        end
    end

    // Read pointer advance: walk the row's slots, then wrap to the next row.
    always_comb begin
        next_row  = out_row;
        next_slot = out_col;
        if (out_col == LAST_SLOT) begin
            next_row  = out_row + 1'b1;
            next_slot = FIRST_SLOT;
        end else if (REORDER) begin
            next_slot = out_col - 1'b1;
        end else begin
            next_slot = out_col + 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        op_sel_d    = op_sel;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_data_d  = out_data;
        out_row_d   = out_row;
        out_col_d   = out_col;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = COMPUTE;
                    cnt_d    = '0;
                    op_sel_d = 1'b0;
                end
            end
            COMPUTE: begin
                if (cnt == COMPUTE_LAST) begin
                    state_d  = DRAIN;
                    cnt_d    = '0;
                    op_sel_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_d     = OUTPUT;
                    cnt_d       = '0;
                    op_sel_d    = 1'b0;
                    out_valid_d = 1'b1;
                    out_row_d   = '0;
                    out_col_d   = FIRST_SLOT;
                    out_last_d  = (ROW == 1) && (FIRST_SLOT == LAST_SLOT);
                    // The top slot is only being written on this edge, so take it from the bus.
                    out_data_d  = (FIRST_SLOT == TOP_SLOT) ? result_in[OUT_WORD_SIZE-1:0]
                                                           : buffer[0][FIRST_SLOT];
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            OUTPUT: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_row_d  = next_row;
                        out_col_d  = next_slot;
                        out_data_d = buffer[next_row][next_slot];
                        out_last_d = (next_row == ROW_LAST) && (next_slot == LAST_SLOT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE);

    // NOTE: sequential state is updated with non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_sel    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            op_sel    <= op_sel_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            out_data  <= out_data_d;
            out_row   <= out_row_d;
            out_col   <= out_col_d;
        end
    end

endmodule

// File: tb/tb_os_result_drain.sv
// Scoreboard bench for os_result_drain: a ROW=1 instance for timing, back-pressure and reset,
// and a ROW=2 instance for multi-row ordering. Honours DRAIN_REORDER_EN when defined.
module tb_os_result_drain;

`ifdef DRAIN_REORDER_EN
    localparam bit REORDER = 1'b1;
`else
    localparam bit REORDER = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [0:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_ready, a_op_sel, a_busy, a_valid, a_last;
    logic [15:0] a_result, a_data;
    logic [0:0]  a_row;
    logic [1:0]  a_col;
    logic        b_start, b_ready, b_op_sel, b_busy, b_valid, b_last;
    logic [31:0] b_result;
    logic [15:0] b_data;
    logic [0:0]  b_row;
    logic [1:0]  b_col;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 0;
    int   rdy_cnt = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    os_result_drain #(.OUT_WORD_SIZE(16), .ROW(1), .COLUMN(4), .INPUTS_LENGTHS(7)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .result_in(a_result), .op_sel(a_op_sel),
        .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
        .out_row(a_row), .out_col(a_col), .out_last(a_last)
    );

    os_result_drain #(.OUT_WORD_SIZE(16), .ROW(2), .COLUMN(4), .INPUTS_LENGTHS(7)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .result_in(b_result), .op_sel(b_op_sel),
        .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_row(b_row), .out_col(b_col), .out_last(b_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // out_ready for dut_a: always high, or the repeating 0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        rdy_cnt = (rdy_cnt == 2) ? 0 : rdy_cnt + 1;
        a_ready = (rdy_mode == 0) || (rdy_cnt == 2);
    end

    // dut_a monitor: scoreboard pop on handshake, hold stability, idle after last word.
    exp_t a_prev;
    bit   a_hold = 1'b0;
    bit   a_idle_chk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (a_idle_chk) begin
                check("a_idle_valid", a_valid, 0);
                check("a_idle_busy", a_busy, 0);
                a_idle_chk = 1'b0;
            end
            if (a_hold) begin
                check("a_hold_valid", a_valid, 1);
                check("a_hold_data", a_data, a_prev.data);
                check("a_hold_col", a_col, a_prev.col);
                check("a_hold_last", a_last, a_prev.last);
            end
            a_hold = 1'b0;
            if (a_valid) begin
                if (a_ready) begin
                    if (q_a.size() == 0) begin
                        check("a_extra_word", 1, 0);
                    end else begin
                        e = q_a.pop_front();
                        check("a_data", a_data, e.data);
                        check("a_row", a_row, e.row);
                        check("a_col", a_col, e.col);
                        check("a_last", a_last, e.last);
                        if (e.last) a_idle_chk = 1'b1;
                    end
                end else begin
                    a_hold       = 1'b1;
                    a_prev.data  = a_data;
                    a_prev.row   = a_row;
                    a_prev.col   = a_col;
                    a_prev.last  = a_last;
                end
            end
        end else begin
            a_hold     = 1'b0;
            a_idle_chk = 1'b0;
        end
    end

    bit b_idle_chk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (b_idle_chk) begin
                check("b_idle_valid", b_valid, 0);
                b_idle_chk = 1'b0;
            end
            if (b_valid && b_ready) begin
                if (q_b.size() == 0) begin
                    check("b_extra_word", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", b_data, e.data);
                    check("b_row", b_row, e.row);
                    check("b_col", b_col, e.col);
                    check("b_last", b_last, e.last);
                    if (e.last) b_idle_chk = 1'b1;
                end
            end
        end
    end

    // One pass on dut_a: pushes the expected words, drives DRAIN data, checks the op_sel timeline.
    task automatic pass_a(input logic [15:0] d [4], input bit start_at_end);
        exp_t e;
        int   n;
        for (int k = 0; k < 4; k++) begin
            int slot = REORDER ? 3 - k : k;
            e.data = d[slot];
            e.row  = 1'b0;
            e.col  = 2'(slot);
            e.last = (k == 3);
            q_a.push_back(e);
        end
        @(posedge clk); #1; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 9) a_result = d[c-9];
            @(negedge clk);
            check($sformatf("a_op_sel_c%0d", c), a_op_sel, c >= 9);
            check($sformatf("a_busy_c%0d", c), a_busy, 1);
            check($sformatf("a_early_valid_c%0d", c), a_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("a_first_valid_c13", a_valid, 1);
        check("a_op_sel_c13", a_op_sel, 0);
        n = 0;
        while (q_a.size() != 0 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        check("a_drain_in_time", n < 200, 1);
        if (start_at_end) begin
            a_start = 1'b1;
            @(posedge clk); #1; a_start = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("a_start_at_last_ignored", a_busy, 0);
            end
        end
    endtask

    // ROW=2 pass on dut_b with stray start pulses in COMPUTE and OUTPUT.
    logic [15:0] db [2][4];
    task automatic pass_b();
        exp_t e;
        int   n;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                int slot = REORDER ? 3 - k : k;
                e.data = db[r][slot];
                e.row  = 1'(r);
                e.col  = 2'(slot);
                e.last = (r == 1) && (k == 3);
                q_b.push_back(e);
            end
        end
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 4) b_start = 1'b1;
            if (c == 5) b_start = 1'b0;
            if (c >= 9) b_result = {db[1][c-9], db[0][c-9]};
            @(negedge clk);
            if (c == 12) check("b_valid_c12", b_valid, 0);
            @(posedge clk); #1;
        end
        b_start = 1'b1;
        @(negedge clk);
        check("b_first_valid_c13", b_valid, 1);
        @(posedge clk); #1; b_start = 1'b0;
        n = 0;
        while (q_b.size() != 0 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        check("b_drain_in_time", n < 200, 1);
        repeat (4) begin
            @(negedge clk);
            check("b_idle_after_pass", b_busy, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d_spec [4];
        logic [15:0] d_rnd [4];
        bit          seen;
        d_spec = '{16'h0AA8, 16'h08CA, 16'h0A51, 16'h0712};
        db     = '{'{16'h1111, 16'h2222, 16'h3333, 16'h4444},
                   '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001}};
        rst = 1'b0;
        a_start = 1'b0; a_ready = 1'b1; a_result = '0;
        b_start = 1'b0; b_ready = 1'b1; b_result = '0;

        repeat (3) @(negedge clk);
        check("rst_op_sel", a_op_sel, 0);
        check("rst_busy", a_busy, 0);
        check("rst_valid", a_valid, 0);
        check("rst_last", a_last, 0);
        check("rst_data", a_data, 0);
        check("rst_row", a_row, 0);
        check("rst_col", a_col, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b1;

        pass_a(d_spec, 1'b0);
        for (int i = 0; i < 4; i++) d_rnd[i] = 16'($urandom);
        pass_a(d_rnd, 1'b1);

        rdy_mode = 1;
        for (int i = 0; i < 4; i++) d_rnd[i] = 16'($urandom);
        pass_a(d_rnd, 1'b1);
        rdy_mode = 0;

        // Reset in the second DRAIN cycle must abort the pass without emitting anything.
        @(posedge clk); #1; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("rst_pre_op_sel", a_op_sel, 1);
        #1; rst = 1'b0;
        #1;
        check("rst_async_op_sel", a_op_sel, 0);
        check("rst_async_busy", a_busy, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_valid) seen = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (a_valid || a_busy) seen = 1'b1;
        end
        check("rst_no_partial_output", seen, 0);
        pass_a(d_spec, 1'b1);

        pass_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
